// File: rtl/alu_exec_pipe.sv
// rtl/alu_exec_pipe.sv - two-stage pipelined ALU execute unit with valid/ready writeback handoff
//
// Purpose: accepts a decoded ALU operation, registers it in S1, computes the
// result into S2, and presents it with its destination address to writeback.
// Back-pressure stalls both stages without losing or duplicating operations.
// NOP codes (101/110/111) pass through S1 and never reach S2 as valid.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   in_valid / in_ready            operation handshake from the command controller
//   alu_op_code, alu_a, alu_b      operation and operands
//   dest_addr                      destination address carried with the result
//   out_valid / out_ready          result handshake to writeback
//   wb_addr, wb_data               presented destination and result
//   retired_count                  hand-offs since reset, wraps at 16 bits
//   flag_zero/carry/ovf            result flags, only when ALU_FLAGS_EN is defined
//
// Optional feature macro: ALU_FLAGS_EN
module alu_exec_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op_code,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [2:0]  dest_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [15:0] retired_count
`ifdef ALU_FLAGS_EN
  ,
  output logic        flag_zero,
  output logic        flag_carry,
  output logic        flag_ovf
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  logic        r_s1_valid;
  logic [2:0]  r_s1_op;
  logic [31:0] r_s1_a;
  logic [31:0] r_s1_b;
  logic [2:0]  r_s1_addr;

  logic        r_s2_valid;
  logic [2:0]  r_s2_addr;
  logic [31:0] r_s2_data;
  logic [15:0] r_retired;

  logic        w_s2_load;
  logic        w_s1_load;
  logic        w_accept;
  logic        w_move;
  logic        w_handoff;
  logic        w_is_op;
  logic [31:0] w_result;

  // S2 can take a new entry when empty or when its current entry leaves;
  // S1 can take input under the same condition or when it is empty.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;
  assign w_accept  = in_valid && w_s1_load;
  assign w_move    = r_s1_valid && w_s2_load;
  assign w_handoff = r_s2_valid && out_ready;

  always_comb begin
    w_result = 32'd0;
    w_is_op  = 1'b1;
    case (r_s1_op)
      OP_ADD:  w_result = r_s1_a + r_s1_b;
      OP_SUB:  w_result = r_s1_a - r_s1_b;
      OP_AND:  w_result = r_s1_a & r_s1_b;
      OP_OR:   w_result = r_s1_a | r_s1_b;
      OP_NOT:  w_result = ~r_s1_a;
      default: w_is_op  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 3'd0;
      r_s1_a     <= 32'd0;
      r_s1_b     <= 32'd0;
      r_s1_addr  <= 3'd0;
    end else begin
      if (w_s1_load) r_s1_valid <= in_valid;
      // Payload only changes on a real accept so unaccepted operand wiggle is ignored.
      if (w_accept) begin
        r_s1_op   <= alu_op_code;
        r_s1_a    <= alu_a;
        r_s1_b    <= alu_b;
        r_s1_addr <= dest_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_addr  <= 3'd0;
      r_s2_data  <= 32'd0;
      r_retired  <= 16'd0;
    end else begin
      // A NOP leaving S1 turns into a bubble in S2.
      if (w_s2_load) r_s2_valid <= r_s1_valid && w_is_op;
      if (w_move && w_is_op) begin
        r_s2_addr <= r_s1_addr;
        r_s2_data <= w_result;
      end
      if (w_handoff) r_retired <= r_retired + 16'd1;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic        w_carry;
  logic        w_ovf;
  logic        r_zero;
  logic        r_carry;
  logic        r_ovf;

  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  // Bit 32 of the widened difference is the unsigned borrow (a < b).
  assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};

  always_comb begin
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_carry = w_sum[32];
        w_ovf   = (r_s1_a[31] == r_s1_b[31]) && (w_sum[31] != r_s1_a[31]);
      end
      OP_SUB: begin
        w_carry = w_diff[32];
        w_ovf   = (r_s1_a[31] != r_s1_b[31]) && (w_diff[31] != r_s1_a[31]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_move && w_is_op) begin
      r_zero  <= (w_result == 32'd0);
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
  end

  assign flag_zero  = r_zero;
  assign flag_carry = r_carry;
  assign flag_ovf   = r_ovf;
`endif

  assign out_valid     = r_s2_valid;
  assign wb_addr       = r_s2_addr;
  assign wb_data       = r_s2_data;
  assign retired_count = r_retired;

endmodule
